// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory bus arbiter.
//   state_e : sequencer states (IDLE / BUSY / RESP)
//   owner_e : which requester owns the current bus access (CORE / DMA)
//   kind_e  : access kind of the granted transfer (FETCH / READ / WRITE)
//   WAIT_W  : width of the wait-state counter (WAIT parameter range 0..7)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ACC_FETCH = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } kind_e;

  localparam int WAIT_W = 3;

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin picker, purely combinational.
// Ports:
//   req_core_i  in  core has a request pending
//   req_dma_i   in  DMA has a request pending
//   last_dma_i  in  previous grant went to DMA (1) or core (0)
//   grant_o     out 1 = grant DMA, 0 = grant core (meaningful only when a
//                   request is pending)
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic req_core_i,
  input  logic req_dma_i,
  input  logic last_dma_i,
  output logic grant_o
);

  always_comb begin
    grant_o = OWN_CORE;
    if (req_core_i && req_dma_i) begin
      // On a tie the requester that was not served last wins.
      grant_o = last_dma_i ? OWN_CORE : OWN_DMA;
    end else if (req_dma_i) begin
      grant_o = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: two-way memory bus arbiter and sequencer between the core's single
// memory port and a DMA requester. Drives a registered address phase, inserts
// WAIT programmable wait states, then waits for bus_ready, and returns a
// one-cycle completion pulse.
//
// Handshake: requests are levels. A requester raises its request with stable
// address/data/mask and holds them until its done pulse; the arbiter samples
// requests only in IDLE, so a level still high during the done (RESP) cycle is
// ignored. bus_ready is only looked at once the wait counter has reached zero.
//
// Build option: define MEM_ARB_DMA_EN to arbitrate the DMA port. Without it the
// DMA inputs are ignored, dma_gnt/dma_done/dma_rdata are 0 and the core is
// always granted.
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   c_ifetch/c_rstrobe/c_wmask  core fetch / read / write requests
//   c_addr, c_wdata, c_io       core word address, write data, IO select
//   c_idone/c_rdone/c_wdone     core completion pulses, c_rdata read data
//   dma_req/dma_we/dma_addr/dma_wdata/dma_wmask  DMA request
//   dma_gnt, dma_done, dma_rdata                 DMA grant/completion/data
//   bus_addr/bus_wdata/bus_be/bus_oe/bus_we/bus_io  registered bus outputs
//   bus_ready, bus_rdata        device handshake and read data
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int RV   = 16,
  parameter int VA   = RV,
  parameter int WAIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c_ifetch,
  input  logic [1:0]           c_rstrobe,
  input  logic [RV/8-1:0]      c_wmask,
  input  logic [VA-RV/16-1:0]  c_addr,
  input  logic [RV-1:0]        c_wdata,
  input  logic                 c_io,
  output logic                 c_idone,
  output logic                 c_rdone,
  output logic                 c_wdone,
  output logic [RV-1:0]        c_rdata,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [VA-RV/16-1:0]  dma_addr,
  input  logic [RV-1:0]        dma_wdata,
  input  logic [RV/8-1:0]      dma_wmask,
  output logic                 dma_gnt,
  output logic                 dma_done,
  output logic [RV-1:0]        dma_rdata,
  output logic [VA-RV/16-1:0]  bus_addr,
  output logic [RV-1:0]        bus_wdata,
  output logic [RV/8-1:0]      bus_be,
  output logic                 bus_oe,
  output logic                 bus_we,
  output logic                 bus_io,
  input  logic                 bus_ready,
  input  logic [RV-1:0]        bus_rdata
);

  localparam int AW = VA - RV/16;
  localparam int BW = RV/8;
  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT);
  localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

  state_e            state_q;
  owner_e            owner_q;
  kind_e             kind_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [AW-1:0]     bus_addr_q;
  logic [RV-1:0]     bus_wdata_q;
  logic [BW-1:0]     bus_be_q;
  logic              bus_oe_q;
  logic              bus_we_q;
  logic              bus_io_q;
  logic              c_idone_q;
  logic              c_rdone_q;
  logic              c_wdone_q;
  logic [RV-1:0]     c_rdata_q;

  // Core request decode; write beats read beats fetch when several are up.
  kind_e         core_kind;
  logic [BW-1:0] core_be;
  logic          core_req;

  always_comb begin
    core_kind = ACC_FETCH;
    core_be   = '1;
    if (|c_wmask) begin
      core_kind = ACC_WRITE;
      core_be   = c_wmask;
    end else if (|c_rstrobe) begin
      core_kind    = ACC_READ;
      core_be      = '0;
      core_be[1:0] = c_rstrobe;
    end
  end

  assign core_req = c_ifetch | (|c_rstrobe) | (|c_wmask);

  owner_e win;
  logic   any_req;

`ifdef MEM_ARB_DMA_EN
  owner_e        last_q;
  logic          dma_gnt_q;
  logic          dma_done_q;
  logic [RV-1:0] dma_rdata_q;
  logic          rr_grant;

  mem_arb_rr u_rr (
    .req_core_i (core_req),
    .req_dma_i  (dma_req),
    .last_dma_i (last_q == OWN_DMA),
    .grant_o    (rr_grant)
  );

  assign win       = rr_grant ? OWN_DMA : OWN_CORE;
  assign any_req   = core_req | dma_req;
  assign dma_gnt   = dma_gnt_q;
  assign dma_done  = dma_done_q;
  assign dma_rdata = dma_rdata_q;
`else
  logic unused_dma;
  assign unused_dma = ^{dma_req, dma_we, dma_addr, dma_wdata, dma_wmask};
  assign win        = OWN_CORE;
  assign any_req    = core_req;
  assign dma_gnt    = 1'b0;
  assign dma_done   = 1'b0;
  assign dma_rdata  = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CORE;
      kind_q      <= ACC_FETCH;
      cnt_q       <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      bus_oe_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_io_q    <= 1'b0;
      c_idone_q   <= 1'b0;
      c_rdone_q   <= 1'b0;
      c_wdone_q   <= 1'b0;
      c_rdata_q   <= '0;
`ifdef MEM_ARB_DMA_EN
      last_q      <= OWN_DMA;   // core wins the first tie after reset
      dma_gnt_q   <= 1'b0;
      dma_done_q  <= 1'b0;
      dma_rdata_q <= '0;
`endif
    end else begin
      // Done outputs are single-cycle pulses.
      c_idone_q <= 1'b0;
      c_rdone_q <= 1'b0;
      c_wdone_q <= 1'b0;
`ifdef MEM_ARB_DMA_EN
      dma_done_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            owner_q <= win;
            cnt_q   <= WAIT_LD;
            state_q <= ST_BUSY;
            if (win == OWN_CORE) begin
              kind_q      <= core_kind;
              bus_addr_q  <= c_addr;
              bus_wdata_q <= c_wdata;
              bus_be_q    <= core_be;
              bus_oe_q    <= (core_kind != ACC_WRITE);
              bus_we_q    <= (core_kind == ACC_WRITE);
              bus_io_q    <= c_io;
            end
`ifdef MEM_ARB_DMA_EN
            else begin
              dma_gnt_q   <= 1'b1;
              kind_q      <= dma_we ? ACC_WRITE : ACC_READ;
              bus_addr_q  <= dma_addr;
              bus_wdata_q <= dma_wdata;
              bus_be_q    <= dma_we ? dma_wmask : '1;
              bus_oe_q    <= ~dma_we;
              bus_we_q    <= dma_we;
              bus_io_q    <= 1'b0;
            end
`endif
          end
        end

        ST_BUSY: begin
          // Minimum wait states first; bus_ready only counts after that.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (bus_ready) begin
            bus_oe_q <= 1'b0;
            bus_we_q <= 1'b0;
            bus_be_q <= '0;
            bus_io_q <= 1'b0;
            state_q  <= ST_RESP;
            if (owner_q == OWN_CORE) begin
              if (kind_q != ACC_WRITE) c_rdata_q <= bus_rdata;
              c_idone_q <= (kind_q == ACC_FETCH);
              c_rdone_q <= (kind_q == ACC_READ);
              c_wdone_q <= (kind_q == ACC_WRITE);
            end
`ifdef MEM_ARB_DMA_EN
            else begin
              if (kind_q != ACC_WRITE) dma_rdata_q <= bus_rdata;
              dma_done_q <= 1'b1;
            end
`endif
          end
        end

        ST_RESP: begin
          // Requester still shows its level this cycle; do not re-arbitrate.
          state_q <= ST_IDLE;
`ifdef MEM_ARB_DMA_EN
          dma_gnt_q <= 1'b0;
          last_q    <= owner_q;
`endif
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
  assign bus_oe    = bus_oe_q;
  assign bus_we    = bus_we_q;
  assign bus_io    = bus_io_q;
  assign c_idone   = c_idone_q;
  assign c_rdone   = c_rdone_q;
  assign c_wdone   = c_wdone_q;
  assign c_rdata   = c_rdata_q;

endmodule
